// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: buffers operand pairs in a small FIFO and issues them
// one at a time to a fixed-latency serial adder. Each captured sum is returned
// on a valid/ready port, so callers never track adder timing.
module serial_add_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int LATENCY = WIDTH + 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     adder_start,
  output logic [WIDTH-1:0]         adder_a,
  output logic [WIDTH-1:0]         adder_b,
  input  logic [WIDTH:0]           adder_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH:0]           out_sum,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              in_ready_q;
  logic              adder_start_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [WIDTH-1:0]  adder_a_q, adder_b_q;
  logic [WIDTH:0]    out_sum_q;
  logic [WIDTH-1:0]  mem_a_q [DEPTH];
  logic [WIDTH-1:0]  mem_b_q [DEPTH];

  logic              push_s;
  logic              pop_s;
  logic              capture_s;

  // in_ready comes from the registered occupancy, so a same-edge pop never frees a slot early
  assign push_s = in_valid && in_ready_q;

  // Next-state, pop and capture decisions for the issue FSM
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pop_s     = 1'b0;
    capture_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != {CW{1'b0}}) begin
          pop_s   = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        timer_d = TW'(LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (timer_q == {TW{1'b0}}) begin
          capture_s = 1'b1;
          state_d   = HOLD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (count_q != {CW{1'b0}}) begin
            pop_s   = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Occupancy update: push and pop on the same edge cancel out
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Operand storage write on an accepted push (contents are flushed via the pointers)
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_a_q[wr_ptr_q] <= in_a;
      mem_b_q[wr_ptr_q] <= in_b;
    end
  end

  // Control, pointer and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= {TW{1'b0}};
      wr_ptr_q      <= {PW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      count_q       <= {CW{1'b0}};
      in_ready_q    <= 1'b1;
      adder_start_q <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      adder_a_q     <= {WIDTH{1'b0}};
      adder_b_q     <= {WIDTH{1'b0}};
      out_sum_q     <= {(WIDTH+1){1'b0}};
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      count_q       <= count_d;
      in_ready_q    <= (count_d < CW'(DEPTH));
      adder_start_q <= (state_d == ISSUE);
      out_valid_q   <= (state_d == HOLD);
      busy_q        <= (state_d != IDLE);
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q  <= rd_ptr_q + PW'(1);
        adder_a_q <= mem_a_q[rd_ptr_q];
        adder_b_q <= mem_b_q[rd_ptr_q];
      end
      if (capture_s) begin
        out_sum_q <= adder_sum;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign adder_start = adder_start_q;
  assign adder_a     = adder_a_q;
  assign adder_b     = adder_b_q;
  assign out_valid   = out_valid_q;
  assign out_sum     = out_sum_q;
  assign count       = count_q;
  assign busy        = busy_q;

endmodule

// File: doc/serial_add_sequencer.md
# serial_add_sequencer

Upstream operand sequencer for the `serial_adder` stage. It accepts operand pairs on a valid/ready input, buffers them in a small FIFO, and issues them to the serial adder one at a time. For each pair it drives a one-cycle start pulse with stable operands, then waits the adder's fixed latency and captures the (WIDTH+1)-bit sum. The sum is returned on a valid/ready output, so upstream logic never has to track adder timing.

## Interface
- WIDTH, 8, operand width; matches the adder's width parameter
- DEPTH, 4, operand FIFO entries; power of two, at least 2
- LATENCY, WIDTH+2, cycles from the adder sampling start to its sum output being valid

- clk  in  1  rising-edge clock shared with the adder
- reset  in  1  synchronous, active-high; integration ties the adder's resetn to ~reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  pair accepted on an edge where in_valid && in_ready
- in_a, in_b  in  WIDTH each  operands
- adder_start  out  1  one-cycle start pulse to the adder
- adder_a, adder_b  out  WIDTH each  operands to the adder; held stable from start until capture
- adder_sum  in  WIDTH+1  adder result
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_sum  out  WIDTH+1  captured sum
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- busy  out  1  high in any state other than IDLE

## Operation
- FIFO: circular buffer with wrapping read/write pointers and an occupancy counter.
  - in_ready = (count < DEPTH). It is computed from the registered count only and ignores a same-cycle pop.
  - A push and a pop on the same edge leave count unchanged.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if count > 0, pop the head into the adder_a/adder_b registers and go to ISSUE.
  - ISSUE: adder_start = 1 for this cycle only. Load timer = LATENCY-1 and go to WAIT.
  - WAIT: decrement the timer each cycle. On the edge where timer == 0, register adder_sum into out_sum and go to HOLD.
  - HOLD: out_valid = 1. On out_valid && out_ready, go to ISSUE (popping the head) if count > 0, otherwise go to IDLE.
- adder_a/adder_b change only on a pop edge and never while in ISSUE or WAIT.
- No new adder_start is issued while a result is waiting in HOLD.
- out_sum is captured verbatim at full WIDTH+1 bits, so the carry is preserved. No arithmetic is performed in this block.
- Results are returned in FIFO order.

## Timing
- Reset values (edge with reset = 1):
  - state IDLE; pointers, count and timer 0
  - adder_start 0, out_valid 0, busy 0
  - adder_a, adder_b and out_sum all 0
  - in_ready reads 1 after the reset edge
- Reset during ISSUE/WAIT/HOLD: FIFO contents are flushed and any pending result is dropped; no stale out_valid appears.
- Latency with an idle, empty block, where edge 0 accepts a pair:
  - edge 1: IDLE→ISSUE; adder_start is high between edge 1 and edge 2
  - edge 2: the adder samples start; state goes to WAIT
  - edge 2+LATENCY: sum captured and out_valid rises (edge 12 with defaults)
- Back-to-back operation with out_ready held high:
  - one result every LATENCY+2 cycles
  - adder_start pulses are exactly LATENCY+2 cycles apart
- out_valid and out_sum stay stable until the handshake completes.
- Occupancy bounds: count never exceeds DEPTH and never underflows. A pop happens only when count > 0.

## Test plan
- Single pair: after reset, push A=8'hFF, B=8'hA1 at edge 0 → adder_start high for exactly one cycle after edge 1; out_valid at edge 12; out_sum = 9'h1A0.
- Ordering: push 8'hAF/8'h71, 8'hFE/8'h91 and 8'hFF/8'hA1 back-to-back with out_ready = 1 → results 9'h120, 9'h18F and 9'h1A0 in that order; start pulses 12 cycles apart.
- Full FIFO: hold out_ready = 0 and offer 6 pairs back-to-back → 5 accepted (1 in the adder, 4 queued); count = 4; in_ready = 0. The 6th pair is accepted on the first edge after the out handshake.
- Backpressure: hold out_ready low for 20 cycles with a result pending → out_valid and out_sum stay constant and adder_start stays 0. Raising out_ready completes the handshake, and the next pulse follows one edge later.
- Simultaneous push and pop: count = 3 and a HOLD handshake on the same edge as an accepted push → count stays 3 and pointers wrap correctly across 8+ transactions.
- Reset mid-operation: assert reset for one cycle during WAIT with 2 pairs queued → after the reset edge count = 0, in_ready = 1, out_valid = 0 and adder_start = 0. A subsequent push of 8'h01/8'h01 yields out_sum = 9'h002 at edge 12.
